mem_stage_wb: RTL

Parametrised memory stage for the pipelined RISC-V core. It contains the data memory with byte/halfword/word access and load sign/zero extension, plus a configurable-latency access sequencer that stalls the pipeline, and the MEM/WB pipeline register. It sits between the execute/memory pipeline register and the writeback stage. It replaces the fixed single-cycle, word-only memory stage.

---
 rtl/mem_stage_wb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_wb.sv
// Memory stage: byte-enabled data memory, latency sequencer, MEM/WB register.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_wb #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic            MemReadM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            StallM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic            MisalignW
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic            access;
    logic            is_load;
    logic            sz_half;
    logic            sz_word;
    logic            mis;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rword;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic [XLEN-1:0] ldata;
    logic            unused_addr;

    assign idx         = ALUResultM[AW+1:2];
    assign lane        = ALUResultM[1:0];
    assign unused_addr = ^ALUResultM[XLEN-1:AW+2];
    assign access      = MemReadM | MemWriteM;
    assign is_load     = MemReadM & ~MemWriteM;
    assign sz_half     = (Funct3M[1:0] == 2'b01);
    assign sz_word     = Funct3M[1];

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = access &
                 ((sz_half & lane[0]) | (sz_word & (lane != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    generate
        if (LATENCY > 0) begin : g_seq
            localparam logic IDLE = 1'b0;
            localparam logic WAIT = 1'b1;

            logic       state;
            logic [2:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (access) begin
                                state <= WAIT;
                                cnt   <= 3'(LATENCY);
                            end
                        end
                        default: begin
                            cnt <= cnt - 3'd1;
                            if (cnt == 3'd1)
                                state <= IDLE;
                        end
                    endcase
                end
            end

            // Reset holds the stage idle so nothing commits while it is asserted.
            assign StallM = ~reset &
                            (((state == IDLE) & access) |
                             ((state == WAIT) & (cnt != 3'd1)));
        end else begin : g_noseq
            assign StallM = 1'b0;
        end
    endgenerate

    always_comb begin
        be    = 4'b1111;
        wdata = WriteDataM;
        if (Funct3M[1:0] == 2'b00) begin
            be    = 4'b0001 << lane;
            wdata = {4{WriteDataM[7:0]}};
        end else if (sz_half) begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WriteDataM[15:0]}};
        end
    end

    assign we = MemWriteM & ~StallM & ~reset & ~mis;

    always_ff @(posedge clk) begin
        if (we & be[0]) mem[idx][7:0]   <= wdata[7:0];
        if (we & be[1]) mem[idx][15:8]  <= wdata[15:8];
        if (we & be[2]) mem[idx][23:16] <= wdata[23:16];
        if (we & be[3]) mem[idx][31:24] <= wdata[31:24];
    end

    assign rword = mem[idx];
    assign rbyte = rword[8*lane +: 8];
    assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (Funct3M)
            3'b000:  ldata = {{(XLEN-8){rbyte[7]}}, rbyte};
            3'b100:  ldata = {{(XLEN-8){1'b0}}, rbyte};
            3'b001:  ldata = {{(XLEN-16){rhalf[15]}}, rhalf};
            3'b101:  ldata = {{(XLEN-16){1'b0}}, rhalf};
            default: ldata = rword;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ReadDataW  <= '0;
            ALUResultW <= '0;
            RdW        <= 5'd0;
            PCPlus4W   <= '0;
            MisalignW  <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            RdW       <= 5'd0;
            MisalignW <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~(is_load & mis);
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= ldata;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            MisalignW  <= mis;
        end
    end

endmodule
